p0_serial_tx: RTL and testbench
===============================

Name: p0_serial_tx

Overview:
- Output-side stage for port P0: buffers each word written to the P0 output register and serialises it onto a single tx line.
- Lets the microcontroller's P0 writes reach an external pin or bench monitor as framed serial words, without stalling the instruction FSMs.
- The upstream P0 write strobe (P0 register load enable) drives wr_en; the P0 register data drives wr_data.

Parameters:
- WIDTH, 16: word width of wr_data and of each serial frame payload.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- wr_en  input  1  enqueue request; one word per cycle while high.
- wr_data  input  WIDTH  word to enqueue.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on tx (START/DATA/STOP).
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  log2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (rst==0 at a rising edge):
  - tx=1, busy=0, full=0, empty=1, count=0, overflow=0.
  - FIFO pointers cleared; FSM to IDLE; bit and baud counters cleared.
  - Takes effect even mid-frame: tx returns high on that edge and the partial frame is abandoned.
- All outputs are registered.
- Frame format, 18 bits total:
  - 1 start bit (0), then WIDTH data bits LSB first, then 1 stop bit (1).
  - Each bit is held for exactly CLKS_PER_BIT cycles, so a frame lasts 18*CLKS_PER_BIT cycles.
- FIFO write:
  - wr_en=1 enqueues wr_data if count<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped, overflow is set to 1, and count is unchanged.
  - overflow clears only on reset.
- FIFO pop:
  - The FSM pops the head into the shift register on the edge it enters START.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: tx=1, busy=0. If empty==0, pop and go to START.
  - START: tx=0. After CLKS_PER_BIT cycles, go to DATA with bit index 0.
  - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the index. After WIDTH bits, go to STOP.
  - STOP: tx=1. After CLKS_PER_BIT cycles: if empty==0, pop and go directly to START (back-to-back, no idle cycle); else go to IDLE.
- Latency: a word written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1, and tx falls at edge N+1.
- empty/full/count reflect state after each edge; a word written at edge N is visible to IDLE at edge N+1.
- wr_en during reset is ignored.
- The baud counter counts 0..CLKS_PER_BIT-1. With CLKS_PER_BIT=1, every state advances each cycle.

Test Plan:
- Single word, CLKS_PER_BIT=4: write 0xA5C3 at edge N.
  - tx=0 for cycles N+1..N+4.
  - Data bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 4 cycles.
  - Stop bit 1 held 4 cycles.
  - busy=1 for 72 cycles, then busy=0 and tx=1.
- Burst with overflow: 6 consecutive writes 0x0001..0x0006 from idle.
  - Words 1–5 accepted (first popped at the second write edge); sixth dropped; overflow=1, full=1.
  - Five frames sent back-to-back: STOP of each is immediately followed by START, no idle cycle.
  - Final frame carries 0x0005.
- Push-while-full with pop: fill the FIFO while a frame is in progress, then assert wr_en on the edge where STOP ends and a pop occurs.
  - Write accepted, overflow stays 0, count stays DEPTH.
- Reset mid-frame: assert rst=0 for one edge during DATA bit 7.
  - On that edge: tx=1, busy=0, empty=1, count=0, overflow=0.
  - No further frame is emitted with no further writes.
- CLKS_PER_BIT=1: write 0xFFFF then 0x0000.
  - Frames of 18 cycles each, contiguous.
  - tx sequence: 0, sixteen 1s, 1, 0, sixteen 0s, 1, then idle high.
- Wrap-around: 3×DEPTH writes paced one per frame.
  - All words emitted in order; pointers wrap with no loss; empty=1 at end.

Source files
------------

// File: rtl/p0_serial_tx.sv
// P0 output stage: FIFO-buffers words written to the P0 register and serialises
// each one as a start bit, WIDTH data bits LSB first, and a stop bit on tx.
module p0_serial_tx #(
   parameter int WIDTH        = 16,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     tx,
   output logic                     busy,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                overflow_q, overflow_d;
   logic                full_q, empty_q;
   logic                pop, push, drop, baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
   assign push = wr_en && ((count_q != CNT_FULL) || pop);
   assign drop = wr_en && !push;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      overflow_d = overflow_q | drop;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      if (state_q != S_IDLE) begin
         baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               pop     = 1'b1;
               state_d = S_START;
               baud_d  = '0;
            end
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         S_STOP: begin
            if (baud_end) begin
               if (!empty_q) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
      end
   end

   // tx/busy are computed from the next state so the registered pins track state_q.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b1;
      case (state_d)
         S_IDLE:  busy_d = 1'b0;
         S_START: tx_d   = 1'b0;
         S_DATA:  tx_d   = shift_d[0];
         S_STOP:  tx_d   = 1'b1;
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         baud_q     <= '0;
         idx_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         baud_q     <= baud_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         full_q     <= (count_d == CNT_FULL);
         empty_q    <= (count_d == '0);
         overflow_q <= overflow_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (rst && push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_p0_serial_tx.sv
// Directed bench for p0_serial_tx: one instance at CLKS_PER_BIT=4, one at 1,
// with a frame decoder on the 4-clock line collecting received words.
module tb_p0_serial_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en4 = 1'b0, wr_en1 = 1'b0;
   logic [15:0] wr_data4 = '0, wr_data1 = '0;
   logic        tx4, busy4, full4, empty4, ovf4;
   logic        tx1, busy1, full1, empty1, ovf1;
   logic [2:0]  count4, count1;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mon_bad = 0;
   logic        mon_en = 1'b1;
   logic [15:0] rx_q[$];
   int          rx_st[$];

   typedef struct {
      logic [15:0] word;
      logic [17:0] frame;   // frame[i] = tx level during bit slot i (slot 0 = start)
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   p0_serial_tx #(.WIDTH(16), .DEPTH(4), .CLKS_PER_BIT(4)) u4 (
      .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_data(wr_data4),
      .tx(tx4), .busy(busy4), .full(full4), .empty(empty4),
      .count(count4), .overflow(ovf4)
   );

   p0_serial_tx #(.WIDTH(16), .DEPTH(4), .CLKS_PER_BIT(1)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1),
      .tx(tx1), .busy(busy1), .full(full1), .empty(empty1),
      .count(count1), .overflow(ovf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("rx_word_count", rx_q.size(), n);
   endtask

   task automatic wait_idle4(input int budget);
      int k = 0;
      tick();
      while (busy4 && k < budget) begin
         tick();
         k++;
      end
      chk("idle_reached", busy4, 0);
   endtask

   // Frame decoder for u4: samples mid-bit, 4 clocks per bit.
   initial begin
      forever begin
         tick();
         if (mon_en && tx4 === 1'b0) begin
            logic [15:0] w;
            int st;
            st = cyc;
            repeat (6) tick();
            for (int b = 0; b < 16; b++) begin
               w[b] = tx4;
               if (b < 15) repeat (4) tick();
            end
            repeat (4) tick();
            if (tx4 !== 1'b1) mon_bad++;
            tick();
            rx_q.push_back(w);
            rx_st.push_back(st);
         end
      end
   end

   initial begin
      logic [36:0] seq1;
      int          exp_cnt[6];
      logic [15:0] w;

      vecs[0] = '{16'hA5C3, 18'b1_1010010111000011_0};
      vecs[1] = '{16'h0001, 18'b1_0000000000000001_0};
      vecs[2] = '{16'h8000, 18'b1_1000000000000000_0};
      vecs[3] = '{16'h3C96, 18'b1_0011110010010110_0};
      exp_cnt = '{1, 1, 2, 3, 4, 4};
      // bit i = tx after edge N+1+i for 0xFFFF then 0x0000 at one clock per bit
      seq1 = {1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0};

      // Reset with writes requested: they must be ignored.
      wr_en4 = 1'b1; wr_data4 = 16'hFFFF;
      wr_en1 = 1'b1; wr_data1 = 16'hFFFF;
      tick(); tick();
      chk("rst_tx", tx4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_full", full4, 0);
      chk("rst_empty", empty4, 1);
      chk("rst_count", count4, 0);
      chk("rst_overflow", ovf4, 0);
      chk("rst_u1", {tx1, busy1, full1, empty1, count1, ovf1}, 8'b1001_0000);
      wr_en4 = 1'b0; wr_en1 = 1'b0;
      rst = 1'b1;
      repeat (3) begin
         tick();
         chk("post_rst_quiet", {busy4, tx4, empty4, count4}, 6'b011_000);
      end

      // Single words at 4 clocks per bit, checked every cycle.
      for (int v = 0; v < 4; v++) begin
         wr_en4 = 1'b1; wr_data4 = vecs[v].word;
         tick();
         wr_en4 = 1'b0;
         chk("single_count", {empty4, count4}, 4'b0_001);
         for (int b = 0; b < 18; b++) begin
            for (int c = 0; c < 4; c++) begin
               tick();
               chk($sformatf("frame%0d_bit%0d", v, b), {busy4, tx4}, {1'b1, vecs[v].frame[b]});
            end
         end
         tick();
         chk("single_end", {busy4, tx4, empty4}, 3'b011);
      end

      // Burst of six from idle: five accepted, sixth dropped.
      rx_q.delete(); rx_st.delete(); mon_bad = 0;
      for (int i = 1; i <= 6; i++) begin
         wr_en4 = 1'b1; wr_data4 = 16'(i);
         tick();
         chk($sformatf("burst_count%0d", i), count4, exp_cnt[i-1]);
         chk($sformatf("burst_full%0d", i), full4, (i >= 5));
         chk($sformatf("burst_ovf%0d", i), ovf4, (i == 6));
         if (i == 2) chk("burst_first_start", {busy4, tx4}, 2'b10);
      end
      wr_en4 = 1'b0;
      wait_rx(5, 500);
      for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
         chk($sformatf("burst_word%0d", i), rx_q[i], i + 1);
         if (i > 0) chk($sformatf("burst_gap%0d", i), rx_st[i] - rx_st[i-1], 72);
      end
      chk("burst_stop_bits", mon_bad, 0);
      repeat (5) tick();
      chk("burst_done", {busy4, tx4, empty4, ovf4}, 4'b0111);

      rst = 1'b0; tick(); rst = 1'b1;
      chk("ovf_cleared", ovf4, 0);

      // Fill during a frame, then push exactly on the STOP->START pop edge.
      rx_q.delete(); rx_st.delete();
      wr_en4 = 1'b1; wr_data4 = 16'hB000;
      tick();
      for (int i = 1; i <= 4; i++) begin
         wr_data4 = 16'hB000 + 16'(i);
         tick();
      end
      wr_en4 = 1'b0;
      chk("fill_full", {full4, count4}, 4'b1_100);
      repeat (68) tick();
      chk("pre_pop_stop", {busy4, tx4, count4}, 5'b11_100);
      wr_en4 = 1'b1; wr_data4 = 16'hB005;
      tick();
      wr_en4 = 1'b0;
      chk("pushpop_count", count4, 4);
      chk("pushpop_full", full4, 1);
      chk("pushpop_ovf", ovf4, 0);
      chk("pushpop_restart", tx4, 0);
      wait_rx(6, 6 * 72 + 50);
      for (int i = 0; i < 6 && i < rx_q.size(); i++)
         chk($sformatf("pushpop_word%0d", i), rx_q[i], 16'hB000 + 16'(i));
      repeat (5) tick();
      chk("pushpop_done", {busy4, empty4, ovf4}, 3'b010);

      // Wrap-around: 3*DEPTH words, one per frame.
      rx_q.delete(); rx_st.delete();
      for (int i = 0; i < 12; i++) begin
         wr_en4 = 1'b1; wr_data4 = 16'h5A00 + 16'(i * 17);
         tick();
         wr_en4 = 1'b0;
         wait_idle4(100);
      end
      wait_rx(12, 100);
      for (int i = 0; i < 12 && i < rx_q.size(); i++)
         chk($sformatf("wrap_word%0d", i), rx_q[i], 16'h5A00 + 16'(i * 17));
      chk("wrap_end", {empty4, count4, ovf4}, 5'b1_000_0);

      // One clock per bit: 0xFFFF then 0x0000, contiguous frames.
      wr_en1 = 1'b1; wr_data1 = 16'hFFFF;
      tick();
      wr_data1 = 16'h0000;
      tick();
      wr_en1 = 1'b0;
      chk("cpb1_seq0", {busy1, tx1}, {1'b1, seq1[0]});
      for (int i = 1; i < 37; i++) begin
         tick();
         chk($sformatf("cpb1_seq%0d", i), {busy1, tx1}, {(i < 36), seq1[i]});
      end
      chk("cpb1_end", {empty1, ovf1}, 2'b10);

      // Reset during DATA bit 7 with a full FIFO and overflow set.
      mon_en = 1'b0;
      wr_en4 = 1'b1; wr_data4 = 16'h0000;
      tick();
      for (int i = 1; i <= 5; i++) begin
         w = 16'h1111 * 16'(i);
         wr_data4 = w;
         tick();
      end
      wr_en4 = 1'b0;
      chk("mid_pre_state", {count4, ovf4}, 4'b100_1);
      repeat (28) tick();
      chk("mid_bit7", {busy4, tx4}, 2'b10);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_tx", tx4, 1);
      chk("mid_rst_busy", busy4, 0);
      chk("mid_rst_empty", empty4, 1);
      chk("mid_rst_count", count4, 0);
      chk("mid_rst_ovf", ovf4, 0);
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("mid_rst_quiet", {busy4, tx4, empty4}, 3'b011);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
